// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: default widths, the zero register and the writeback entry payload.
package mips_pkg;

    localparam int unsigned DEF_DATA_BITS = 32;
    localparam int unsigned DEF_ADDR_BITS = 5;

    localparam logic [DEF_ADDR_BITS-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_DATA_BITS-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of pending ALU writebacks; exposes every slot youngest-first for hazard lookup.
module wb_fifo
    import mips_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  wb_entry_t             push_data_i,
    input  logic                  pop_i,
    output wb_entry_t             head_o,
    output logic [CNT_W-1:0]      count_o,
    output wb_entry_t [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]      valid_o
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[tail_q] = push_data_i;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop_ok) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

    // Slot i is the (i+1)-th most recent push; valid while within the occupancy.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_o[i] = mem_q[tail_q - PTR_W'(i + 1)];
            valid_o[i]   = (CNT_W'(i) < count_q);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port; loads win, ALU results queue.
module writeback_arbiter
    import mips_pkg::*;
#(
    parameter  int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter  int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 AluValid,
    output logic                 AluReady,
    input  logic [ADDR_BITS-1:0] AluAddress,
    input  logic [DATA_BITS-1:0] AluData,
    input  logic                 MemValid,
    input  logic [ADDR_BITS-1:0] MemAddress,
    input  logic [DATA_BITS-1:0] MemData,
    output logic                 WriteEnable,
    output logic [ADDR_BITS-1:0] DAddress,
    output logic [DATA_BITS-1:0] DData,
    input  logic [ADDR_BITS-1:0] QueryAddress,
    output logic                 QueryHit,
    output logic [DATA_BITS-1:0] QueryData,
    output logic [CNT_W-1:0]     Count,
    output logic                 Empty
);

    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(ZERO_REG);

    wb_entry_t                  fifo_head;
    wb_entry_t                  push_data;
    wb_entry_t [FIFO_DEPTH-1:0] fifo_entries;
    logic [FIFO_DEPTH-1:0]      fifo_valid;
    logic [CNT_W-1:0]           fifo_count;
    logic                       alu_push;
    logic                       mem_write;
    logic                       fifo_pop;

    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] daddr_q, daddr_d;
    logic [DATA_BITS-1:0] ddata_q, ddata_d;

    // Ready looks only at registered occupancy so a same-cycle pop never frees a slot.
    assign AluReady  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign alu_push  = AluValid && AluReady && (AluAddress != ZERO_ADDR);
    assign mem_write = MemValid && (MemAddress != ZERO_ADDR);
    assign fifo_pop  = !mem_write && (fifo_count != '0);
    assign push_data = '{addr: AluAddress, data: AluData};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (alu_push),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

    always_comb begin
        we_d    = 1'b0;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
        if (mem_write) begin
            we_d    = 1'b1;
            daddr_d = MemAddress;
            ddata_d = MemData;
        end else if (fifo_pop) begin
            we_d    = 1'b1;
            daddr_d = fifo_head.addr;
            ddata_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            daddr_q <= '0;
            ddata_q <= '0;
        end else begin
            we_q    <= we_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
        end
    end

    // Scan oldest to youngest so the youngest matching write is the one left standing.
    always_comb begin
        QueryHit  = 1'b0;
        QueryData = '0;
        if (QueryAddress != ZERO_ADDR) begin
            if (we_q && (daddr_q == QueryAddress)) begin
                QueryHit  = 1'b1;
                QueryData = ddata_q;
            end
            for (int i = int'(FIFO_DEPTH) - 1; i >= 0; i--) begin
                if (fifo_valid[i] && (fifo_entries[i].addr == QueryAddress)) begin
                    QueryHit  = 1'b1;
                    QueryData = fifo_entries[i].data;
                end
            end
        end
    end

    assign WriteEnable = we_q;
    assign DAddress    = daddr_q;
    assign DData       = ddata_q;
    assign Count       = fifo_count;
    assign Empty       = (fifo_count == '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus FIFO-model streams and a mid-stream reset.
module tb_writeback_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        AluValid;
    logic        AluReady;
    logic [4:0]  AluAddress;
    logic [31:0] AluData;
    logic        MemValid;
    logic [4:0]  MemAddress;
    logic [31:0] MemData;
    logic        WriteEnable;
    logic [4:0]  DAddress;
    logic [31:0] DData;
    logic [4:0]  QueryAddress;
    logic        QueryHit;
    logic [31:0] QueryData;
    logic [2:0]  Count;
    logic        Empty;

    int n_vec = 0;
    int n_err = 0;

    writeback_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .AluValid     (AluValid),
        .AluReady     (AluReady),
        .AluAddress   (AluAddress),
        .AluData      (AluData),
        .MemValid     (MemValid),
        .MemAddress   (MemAddress),
        .MemData      (MemData),
        .WriteEnable  (WriteEnable),
        .DAddress     (DAddress),
        .DData        (DData),
        .QueryAddress (QueryAddress),
        .QueryHit     (QueryHit),
        .QueryData    (QueryData),
        .Count        (Count),
        .Empty        (Empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  qa;
        logic        we;
        logic [4:0]  da;
        logic [31:0] dd;
        logic [2:0]  cnt;
        logic        rdy;
        logic        qh;
        logic [31:0] qd;
    } vec_t;

    vec_t vecs[11];
    vec_t qvecs[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: drive inputs, clock once, compare registered and query outputs.
    task automatic run_vec(input vec_t v, input string tag);
        AluValid     = v.av;
        AluAddress   = v.aa;
        AluData      = v.ad;
        MemValid     = v.mv;
        MemAddress   = v.ma;
        MemData      = v.md;
        QueryAddress = v.qa;
        @(posedge clk);
        #1;
        chk({tag, " we"},    64'(WriteEnable), 64'(v.we));
        chk({tag, " daddr"}, 64'(DAddress),    64'(v.da));
        chk({tag, " ddata"}, 64'(DData),       64'(v.dd));
        chk({tag, " count"}, 64'(Count),       64'(v.cnt));
        chk({tag, " empty"}, 64'(Empty),       64'(v.cnt == 3'd0));
        chk({tag, " ready"}, 64'(AluReady),    64'(v.rdy));
        chk({tag, " qhit"},  64'(QueryHit),    64'(v.qh));
        chk({tag, " qdata"}, 64'(QueryData),   64'(v.qd));
    endtask

    // Pushes n ALU writes (addr base.., data 0x100+addr) while loads occupy the first mem_cycles cycles.
    task automatic stream(input int n, input int base, input int mem_cycles, input string tag);
        logic [36:0] mq[$];
        logic [36:0] e;
        int          sent = 0;
        int          c    = 0;
        logic        fire;
        logic        exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        while ((sent < n || mq.size() > 0) && c < 40) begin
            AluValid   = (sent < n);
            AluAddress = 5'(base + sent);
            AluData    = 32'h100 + 32'(base + sent);
            MemValid   = (c < mem_cycles);
            MemAddress = 5'd9;
            MemData    = 32'hE00 + 32'(c);
            #1;
            chk({tag, " ready"}, 64'(AluReady), 64'(mq.size() != DEPTH));
            fire = AluValid && (mq.size() != DEPTH);
            @(posedge clk);
            #1;
            exp_we = 1'b0;
            exp_a  = DAddress;
            exp_d  = DData;
            if (MemValid) begin
                exp_we = 1'b1;
                exp_a  = 5'd9;
                exp_d  = 32'hE00 + 32'(c);
            end else if (mq.size() > 0) begin
                e      = mq.pop_front();
                exp_we = 1'b1;
                exp_a  = e[36:32];
                exp_d  = e[31:0];
            end
            if (fire) begin
                mq.push_back({AluAddress, AluData});
                sent++;
            end
            chk({tag, " we"}, 64'(WriteEnable), 64'(exp_we));
            if (exp_we) begin
                chk({tag, " daddr"}, 64'(DAddress), 64'(exp_a));
                chk({tag, " ddata"}, 64'(DData),    64'(exp_d));
            end
            chk({tag, " count"}, 64'(Count), 64'(mq.size()));
            c++;
        end
        AluValid = 1'b0;
        MemValid = 1'b0;
        chk({tag, " sent"}, 64'(sent), 64'(n));
    endtask

    initial begin
        rst_n        = 1'b1;
        AluValid     = 1'b0;
        AluAddress   = '0;
        AluData      = '0;
        MemValid     = 1'b0;
        MemAddress   = '0;
        MemData      = '0;
        QueryAddress = '0;

        //               av    aa     ad          mv    ma     md         qa      we    da     dd          cnt   rdy   qh    qd
        vecs[0]  = '{1'b1, 5'd3,  32'h1234, 1'b0, 5'd0, 32'h0,    5'd3,  1'b0, 5'd0,  32'h0,    3'd1, 1'b1, 1'b1, 32'h1234};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    5'd3,  1'b1, 5'd3,  32'h1234, 3'd0, 1'b1, 1'b1, 32'h1234};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    5'd3,  1'b0, 5'd3,  32'h1234, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 5'd6,  32'hBBBB, 1'b1, 5'd5, 32'hAAAA, 5'd6,  1'b1, 5'd5,  32'hAAAA, 3'd1, 1'b1, 1'b1, 32'hBBBB};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    5'd5,  1'b1, 5'd6,  32'hBBBB, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    5'd6,  1'b0, 5'd6,  32'hBBBB, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 5'd0,  32'h55,   1'b1, 5'd0, 32'h66,   5'd0,  1'b0, 5'd6,  32'hBBBB, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 5'd10, 32'hA0,   1'b1, 5'd9, 32'h99,   5'd9,  1'b1, 5'd9,  32'h99,   3'd1, 1'b1, 1'b1, 32'h99};
        vecs[8]  = '{1'b1, 5'd11, 32'hB0,   1'b1, 5'd0, 32'h77,   5'd11, 1'b1, 5'd10, 32'hA0,   3'd1, 1'b1, 1'b1, 32'hB0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    5'd10, 1'b1, 5'd11, 32'hB0,   3'd0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    5'd11, 1'b0, 5'd11, 32'hB0,   3'd0, 1'b1, 1'b0, 32'h0};

        qvecs[0] = '{1'b1, 5'd7,  32'h1,    1'b1, 5'd9, 32'h91,   5'd7,  1'b1, 5'd9,  32'h91,   3'd1, 1'b1, 1'b1, 32'h1};
        qvecs[1] = '{1'b1, 5'd7,  32'h2,    1'b1, 5'd9, 32'h92,   5'd7,  1'b1, 5'd9,  32'h92,   3'd2, 1'b1, 1'b1, 32'h2};
        qvecs[2] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9, 32'h93,   5'd7,  1'b1, 5'd9,  32'h93,   3'd2, 1'b1, 1'b1, 32'h2};

        // Power-on reset, asserted and released away from the rising edge.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst we",    64'(WriteEnable), 64'(1'b0));
        chk("rst daddr", 64'(DAddress),    64'(5'd0));
        chk("rst ddata", 64'(DData),       64'(32'd0));
        chk("rst count", 64'(Count),       64'(3'd0));
        chk("rst empty", 64'(Empty),       64'(1'b1));
        chk("rst ready", 64'(AluReady),    64'(1'b1));
        for (int a = 0; a < 32; a++) begin
            QueryAddress = 5'(a);
            #0.1;
            chk("rst qhit", 64'(QueryHit), 64'(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        stream(5, 1, 5, "full");
        stream(8, 12, 3, "wrap");

        for (int i = 0; i < 3; i++) begin
            run_vec(qvecs[i], $sformatf("query%0d", i));
        end

        // Mid-stream reset: pending entries vanish without a clock edge.
        AluValid = 1'b0;
        MemValid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mrst qhit",  64'(QueryHit),    64'(1'b0));
        chk("mrst qdata", 64'(QueryData),   64'(32'd0));
        chk("mrst count", 64'(Count),       64'(3'd0));
        chk("mrst empty", 64'(Empty),       64'(1'b1));
        chk("mrst ready", 64'(AluReady),    64'(1'b1));
        chk("mrst we",    64'(WriteEnable), 64'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post rst we",    64'(WriteEnable), 64'(1'b0));
            chk("post rst count", 64'(Count),       64'(3'd0));
            chk("post rst qhit",  64'(QueryHit),    64'(1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
